// File: rtl/operand_fetch_stage_pkg.sv
// Shared types and decode helpers for the operand fetch stage.
// Optional macro OPERAND_FETCH_BYPASS_EN enables writeback forwarding (see register file / top).
package operand_fetch_stage_pkg;

  localparam int unsigned NUM_REGS       = 32;
  localparam int unsigned REG_ADDR_W     = $clog2(NUM_REGS);
  localparam int unsigned REGISTER_WIDTH = 32;

  // RV32I-style encoding: opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20]
  typedef logic [31:0]           instruction_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  function automatic opcode_e get_opcode(input instruction_t instr);
    return opcode_e'(instr[6:0]);
  endfunction

  function automatic reg_addr_t get_rd(input instruction_t instr);
    return instr[11:7];
  endfunction

  function automatic reg_addr_t get_rs1(input instruction_t instr);
    return instr[19:15];
  endfunction

  function automatic reg_addr_t get_rs2(input instruction_t instr);
    return instr[24:20];
  endfunction

  function automatic logic uses_rs1(input instruction_t instr);
    case (get_opcode(instr))
      OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_OP, OPC_BRANCH, OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input instruction_t instr);
    case (get_opcode(instr))
      OPC_STORE, OPC_OP, OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input instruction_t instr);
    case (get_opcode(instr))
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP, OPC_LUI, OPC_JALR, OPC_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/operand_fetch_stage_register_file.sv
// Integer register file: 2 read ports, 1 write port, x0 hardwired to zero.
// With OPERAND_FETCH_BYPASS_EN defined, reads forward same-cycle write data.
module operand_fetch_stage_register_file #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_ADDR_W = $clog2(NUM_REGS),
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_en,
  input  logic [REG_ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]     i_wr_data,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_a,
  output logic [DATA_W-1:0]     o_rd_data_a,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0]     o_rd_data_b
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              w_wr_live;

  assign w_wr_live = i_wr_en && (i_wr_addr != '0);

  // Storage: cleared on reset, writes to x0 dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_live) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Read ports: x0 reads zero, optional forwarding of the in-flight write
  always_comb begin
    o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
    o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];
`ifdef OPERAND_FETCH_BYPASS_EN
    if (w_wr_live && (i_wr_addr == i_rd_addr_a)) o_rd_data_a = i_wr_data;
    if (w_wr_live && (i_wr_addr == i_rd_addr_b)) o_rd_data_b = i_wr_data;
`endif
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: register file read, scoreboard (RAW/WAW stall), output register.
// With OPERAND_FETCH_BYPASS_EN defined, same-cycle writeback clears hazards and forwards data.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int unsigned NUM_REGS   = operand_fetch_stage_pkg::NUM_REGS,
  parameter int unsigned REG_ADDR_W = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  instruction_t              in_instruction,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_W-1:0]     wb_rd,
  input  logic [REGISTER_WIDTH-1:0] wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output instruction_t              out_instruction,
  output logic [REGISTER_WIDTH-1:0] out_rs1_value,
  output logic [REGISTER_WIDTH-1:0] out_rs2_value
);

  logic [NUM_REGS-1:0]       r_pending;
  logic [NUM_REGS-1:0]       w_pending_next;
  logic [NUM_REGS-1:0]       w_pending_eff;
  logic [NUM_REGS-1:0]       w_wb_mask;
  logic [REG_ADDR_W-1:0]     w_rd;
  logic [REG_ADDR_W-1:0]     w_rs1;
  logic [REG_ADDR_W-1:0]     w_rs2;
  logic                      w_uses_rs1;
  logic                      w_uses_rs2;
  logic                      w_writes_rd;
  logic                      w_hazard;
  logic                      w_xfer;
  logic [REGISTER_WIDTH-1:0] w_rs1_value;
  logic [REGISTER_WIDTH-1:0] w_rs2_value;

  operand_fetch_stage_register_file #(
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W),
    .DATA_W     (REGISTER_WIDTH)
  ) u_register_file (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (wb_valid),
    .i_wr_addr   (wb_rd),
    .i_wr_data   (wb_data),
    .i_rd_addr_a (w_rs1),
    .o_rd_data_a (w_rs1_value),
    .i_rd_addr_b (w_rs2),
    .o_rd_data_b (w_rs2_value)
  );

  // Decode fields and evaluate hazard / handshake
  always_comb begin
    w_rd        = get_rd(in_instruction);
    w_rs1       = get_rs1(in_instruction);
    w_rs2       = get_rs2(in_instruction);
    w_uses_rs1  = uses_rs1(in_instruction);
    w_uses_rs2  = uses_rs2(in_instruction);
    w_writes_rd = writes_rd(in_instruction);

    w_wb_mask = '0;
    if (wb_valid && (wb_rd != '0)) w_wb_mask[wb_rd] = 1'b1;

`ifdef OPERAND_FETCH_BYPASS_EN
    w_pending_eff = r_pending & ~w_wb_mask;
`else
    w_pending_eff = r_pending;
`endif
    w_pending_eff[0] = 1'b0;

    w_hazard = (w_uses_rs1  && w_pending_eff[w_rs1]) ||
               (w_uses_rs2  && w_pending_eff[w_rs2]) ||
               (w_writes_rd && w_pending_eff[w_rd]);
    in_ready = (!out_valid || out_ready) && !w_hazard;
    w_xfer   = in_valid && in_ready;
  end

  // Scoreboard next state: clear on writeback first so a same-index issue wins
  always_comb begin
    w_pending_next = r_pending & ~w_wb_mask;
    if (w_xfer && w_writes_rd && (w_rd != '0)) w_pending_next[w_rd] = 1'b1;
    w_pending_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_next;
  end

  // Output register: load on transfer, drain on consume, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_rs1_value   <= '0;
      out_rs2_value   <= '0;
    end else if (w_xfer) begin
      out_valid       <= 1'b1;
      out_instruction <= in_instruction;
      out_rs1_value   <= w_rs1_value;
      out_rs2_value   <= w_rs2_value;
    end else if (out_ready) begin
      out_valid       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed self-checking bench for operand_fetch_stage.
// Expectations follow OPERAND_FETCH_BYPASS_EN when it is defined for the build.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  instruction_t              in_instruction;
  logic                      wb_valid;
  logic [REG_ADDR_W-1:0]     wb_rd;
  logic [REGISTER_WIDTH-1:0] wb_data;
  logic                      out_valid;
  logic                      out_ready;
  instruction_t              out_instruction;
  logic [REGISTER_WIDTH-1:0] out_rs1_value;
  logic [REGISTER_WIDTH-1:0] out_rs2_value;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  operand_fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_rs1_value   (out_rs1_value),
    .out_rs2_value   (out_rs2_value)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] f_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] f_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] held_instr;

    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_instruction = '0;
    wb_valid       = 1'b0;
    wb_rd          = '0;
    wb_data        = '0;
    out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instruction, 32'd0);
    chk("rst_out_rs1", out_rs1_value, 32'd0);
    chk("rst_out_rs2", out_rs2_value, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Write x5 then read it through ADDI x6, x5, 0
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b1; in_instruction = f_addi(5'd6, 5'd5, 12'd0);
    #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_instr", out_instruction, f_addi(5'd6, 5'd5, 12'd0));
    chk("t1_out_rs1", out_rs1_value, 32'h1234);
    chk("t1_out_rs2", out_rs2_value, 32'd0);
    in_instruction = f_add(5'd8, 5'd6, 5'd0);
    #1 chk("t1_raw_x6_stall", 32'(in_ready), 32'd0);
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
    tick();
    wb_valid = 1'b0;
    chk("t1_drain", 32'(out_valid), 32'd0);

    // RAW on x3 resolved by writeback of 0xAB
    in_valid = 1'b1; in_instruction = f_addi(5'd3, 5'd0, 12'd1);
    #1 chk("t2_prod_ready", 32'(in_ready), 32'd1);
    tick();
    in_instruction = f_add(5'd9, 5'd3, 5'd0);
    #1 chk("t2_raw_stall", 32'(in_ready), 32'd0);
    tick();
    chk("t2_stall_hold", 32'(in_ready), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hAB;
`ifdef OPERAND_FETCH_BYPASS_EN
    #1 chk("t2_wb_cycle_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
`else
    #1 chk("t2_wb_cycle_ready", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1 chk("t2_after_wb_ready", 32'(in_ready), 32'd1);
    tick();
`endif
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_out_rs1", out_rs1_value, 32'hAB);
    chk("t2_out_instr", out_instruction, f_add(5'd9, 5'd3, 5'd0));

    // Back-pressure: hold 4 cycles; queued ADDI's unused rs2 field names pending x9
    held_instr = f_add(5'd9, 5'd3, 5'd0);
    out_ready = 1'b0;
    in_instruction = f_addi(5'd10, 5'd0, 12'd9);
    for (int unsigned k = 0; k < 4; k++) begin
      #1 chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("t3_hold_valid", 32'(out_valid), 32'd1);
      chk("t3_hold_instr", out_instruction, held_instr);
      chk("t3_hold_rs1", out_rs1_value, 32'hAB);
    end
    out_ready = 1'b1;
    #1 chk("t3_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t3_next_valid", 32'(out_valid), 32'd1);
    chk("t3_next_instr", out_instruction, f_addi(5'd10, 5'd0, 12'd9));
    chk("t3_next_rs1", out_rs1_value, 32'd0);

    // Writeback to x0 ignored; reading x0 never hazards
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    in_instruction = f_add(5'd11, 5'd0, 5'd0);
    #1 chk("t4_x0_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    chk("t4_x0_rs1", out_rs1_value, 32'd0);
    chk("t4_x0_rs2", out_rs2_value, 32'd0);

    // WAW on x7
    in_instruction = f_lui(5'd7, 20'h1);
    #1 chk("t5_first_ready", 32'(in_ready), 32'd1);
    tick();
    #1 chk("t5_waw_stall", 32'(in_ready), 32'd0);
    tick();
    chk("t5_waw_hold", 32'(in_ready), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
`ifdef OPERAND_FETCH_BYPASS_EN
    #1 chk("t5_wb_cycle_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
`else
    #1 chk("t5_wb_cycle_ready", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1 chk("t5_after_wb_ready", 32'(in_ready), 32'd1);
    tick();
`endif
    chk("t5_second_issued", out_instruction, f_lui(5'd7, 20'h1));
    #1 chk("t5_x7_pending_again", 32'(in_ready), 32'd0);

    // Reset while stalled with out_valid=1 and pending bits set
    out_ready = 1'b0;
    tick();
    chk("t6_stalled_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_out_instr", out_instruction, 32'd0);
    chk("t6_rst_pending_clear", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_instruction = f_addi(5'd12, 5'd5, 12'd0);
    #1 chk("t6_post_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t6_post_valid", 32'(out_valid), 32'd1);
    chk("t6_x5_cleared", out_rs1_value, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
